ro_sweep_ctrl: RTL and testbench
================================

Name: ro_sweep_ctrl

Overview:
- Parametrised, multi-channel measurement-window controller for the ring-oscillator (RO) frequency experiment.
- On `roen`, it walks through NUM_CH oscillators in turn. Each channel gets a settle period, then a gated count window during which `counteren` enables the external edge counter.
- It sits between the top-level experiment enable and the per-RO enable muxes and edge counter.
- Adds over the previous generation: configurable timings and width, channel sweep, abort on `roen` drop, reset, done/abort status.

Parameters:
- CNT_W, 32, width of the internal cycle counter.
- SETTLE_CYCLES, 2000000000, cycles each RO runs before its window opens; legal range 1..2^CNT_W-1.
- WINDOW_CYCLES, 500000, cycles `counteren` stays high per channel; legal range 1..2^CNT_W-1.
- NUM_CH, 4, number of oscillators swept; must be ≥1.
- CH_W, $clog2(NUM_CH) with minimum 1, width of `ch_idx`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- roen  in  1  experiment enable, level-sensitive.
- counteren  out  1  high only during a count window.
- ro_sel  out  NUM_CH  one-hot RO enable for the current channel; zero outside SETTLE and WINDOW.
- ch_idx  out  CH_W  current channel index.
- counter_ctrl_state  out  2  current FSM state.
- busy  out  1  high in SETTLE or WINDOW.
- done  out  1  one-cycle pulse when the sweep completes.
- aborted  out  1  one-cycle pulse when `roen` drops mid-sweep.

Behaviour:
- State encoding: IDLE=00, SETTLE=01, WINDOW=10, DONE=11. The state is registered.
- Moore outputs, decoded from the registered state and channel only:
  - `counteren` = (state==WINDOW).
  - `busy` = SETTLE or WINDOW.
  - `ro_sel` = (1<<ch_idx) when busy, otherwise 0.
  - `counter_ctrl_state` = state.
- Reset (`rst` sampled high at a clk edge):
  - state=IDLE, cnt=0, ch_idx=0, done=0, aborted=0.
  - All outputs are therefore 0.
  - Reset overrides all other events, including mid-window.
- IDLE: cnt=0, ch_idx=0. If `roen`=1, go to SETTLE next cycle.
- SETTLE:
  - If `roen`=0: go to IDLE and pulse `aborted`.
  - Else if cnt==SETTLE_CYCLES-1: go to WINDOW, cnt<=0.
  - Else cnt<=cnt+1.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- WINDOW:
  - If `roen`=0: go to IDLE and pulse `aborted`. `counteren` falls on the same edge.
  - Else if cnt==WINDOW_CYCLES-1:
    - If ch_idx==NUM_CH-1: go to DONE.
    - Else ch_idx<=ch_idx+1, go to SETTLE.
    - In both cases cnt<=0.
  - Else cnt<=cnt+1.
  - `counteren` is high for exactly WINDOW_CYCLES consecutive cycles per channel.
- DONE:
  - `done` is registered high for the first cycle in DONE only.
  - Hold DONE until `roen`=0, then go to IDLE (no `aborted` pulse).
- Latency: `roen` first sampled high at edge E puts the first `counteren` high at edge E+SETTLE_CYCLES.
- Arithmetic: cnt is unsigned CNT_W bits and never wraps; terminal compares are equality against (param-1).
- `done` and `aborted` are never both high in the same cycle.
- Illegal state encodings cannot occur with 2 bits. ch_idx ≥ NUM_CH forces IDLE.

Optional Feature:
- Macro: RO_SWEEP_AUTO_REARM_EN.
- Defined: in DONE, if `roen` is still 1 on the cycle after the `done` pulse, restart at SETTLE with ch_idx=0 and cnt=0, giving continuous sweeps. `roen`=0 in DONE still goes to IDLE.
- Undefined: DONE holds until `roen`=0, as above.

Decomposition:
- Shared package `ro_exp_pkg`: state enum (IDLE/SETTLE/WINDOW/DONE with the encodings above), default timing constants.
- One natural sub-module, `ro_cycle_timer`: a loadable terminal-count counter with clear, terminal-value input and `tc` output, reused by the edge-counter block.
- FSM and channel logic stay in the top.

Test Plan (SETTLE_CYCLES=4, WINDOW_CYCLES=3, NUM_CH=2, macro undefined unless stated):
- Reset then `roen` high held: `ro_sel`=01 for 7 cycles with `counteren` high on cycles 5-7; then `ro_sel`=10 with the same pattern. `done` pulses once; state=11 holds.
- `roen` dropped on the 2nd WINDOW cycle of ch0: `counteren`=0 and state=00 next cycle, `aborted`=1 for one cycle, `done` never asserts.
- `roen` dropped during ch1 SETTLE: `aborted` pulse, `ro_sel`=00, ch_idx=0 next cycle. Re-raising `roen` restarts at ch0.
- `rst` asserted mid-WINDOW with `roen`=1: all outputs 0 next cycle and no `aborted` pulse. After `rst` is released the sweep restarts from ch0.
- SETTLE_CYCLES=1, WINDOW_CYCLES=1, NUM_CH=1: `counteren` high exactly 1 cycle at E+1; `done` at E+2.
- RO_SWEEP_AUTO_REARM_EN defined, `roen` held: `done` pulses every 2·(4+3)+1=15 cycles with continuous sweeps; `roen`=0 in DONE goes to IDLE.

Source files
------------

// File: rtl/ro_exp_pkg.sv
// Shared types and default timing for the ring-oscillator sweep experiment.
package ro_exp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      SETTLE = 2'b01,
      WINDOW = 2'b10,
      DONE   = 2'b11
   } ro_state_e;

   localparam int unsigned DEF_CNT_W         = 32;
   localparam int unsigned DEF_SETTLE_CYCLES = 32'd2000000000;
   localparam int unsigned DEF_WINDOW_CYCLES = 32'd500000;
   localparam int unsigned DEF_NUM_CH        = 4;

endpackage

// File: rtl/ro_cycle_timer.sv
// Loadable terminal-count cycle counter. tc is high while cnt equals term;
// the counter saturates at term instead of wrapping.
module ro_cycle_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic [CNT_W-1:0] term,
   output logic             tc,
   output logic [CNT_W-1:0] cnt
);

   assign tc = (cnt == term);

   // Count register: clear wins over load, load wins over increment.
   always_ff @(posedge clk) begin
      if (rst || clear)  cnt <= '0;
      else if (load)     cnt <= load_val;
      else if (en && !tc) cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/ro_sweep_ctrl.sv
// Multi-channel RO measurement-window controller: per channel a settle
// period then a count window with counteren high. Sweeps NUM_CH channels.
// Optional: define RO_SWEEP_AUTO_REARM_EN to restart the sweep from DONE
// while roen stays high.
module ro_sweep_ctrl
   import ro_exp_pkg::*;
#(
   parameter int          CNT_W         = DEF_CNT_W,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
   parameter int          NUM_CH        = DEF_NUM_CH,
   parameter int          CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              roen,
   output logic              counteren,
   output logic [NUM_CH-1:0] ro_sel,
   output logic [CH_W-1:0]   ch_idx,
   output logic [1:0]        counter_ctrl_state,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   localparam logic [CNT_W-1:0] SET_TERM = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WIN_TERM = CNT_W'(WINDOW_CYCLES - 1);
   localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

   ro_state_e        state_q, state_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic             done_q, aborted_q;
   logic             in_busy, tc, tmr_clr;
   logic [CNT_W-1:0] term, cnt;

   assign in_busy = (state_q == SETTLE) || (state_q == WINDOW);
   assign term    = (state_q == WINDOW) ? WIN_TERM : SET_TERM;
   // Timer restarts on every state change and idles at zero outside busy.
   assign tmr_clr = (state_d != state_q) || !in_busy;

   ro_cycle_timer #(.CNT_W(CNT_W)) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clr),
      .en       (in_busy),
      .load     (1'b0),
      .load_val ('0),
      .term     (term),
      .tc       (tc),
      .cnt      (cnt)
   );

   // Next-state and channel stepping.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      if (32'(ch_q) >= 32'(NUM_CH)) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:   if (roen) state_d = SETTLE;
            SETTLE: begin
               if (!roen)   state_d = IDLE;
               else if (tc) state_d = WINDOW;
            end
            WINDOW: begin
               if (!roen) state_d = IDLE;
               else if (tc) begin
                  if (ch_q == LAST_CH) state_d = DONE;
                  else begin
                     ch_d    = ch_q + CH_W'(1);
                     state_d = SETTLE;
                  end
               end
            end
            DONE: begin
               if (!roen) state_d = IDLE;
`ifdef RO_SWEEP_AUTO_REARM_EN
               else begin
                  state_d = SETTLE;
                  ch_d    = '0;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
      if (state_d == IDLE) ch_d = '0;
   end

   // State, channel and status-pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ch_q      <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_q      <= ch_d;
         done_q    <= (state_d == DONE) && (state_q != DONE);
         aborted_q <= in_busy && !roen;
      end
   end

   assign counteren          = (state_q == WINDOW);
   assign busy               = in_busy;
   assign ro_sel             = in_busy ? (NUM_CH'(1) << ch_q) : '0;
   assign ch_idx             = ch_q;
   assign counter_ctrl_state = state_q;
   assign done               = done_q;
   assign aborted            = aborted_q;

endmodule

// File: tb/tb_ro_sweep_ctrl.sv
// Bench for ro_sweep_ctrl: table vectors, corner sequences, random roen/rst
// compared against a sweep-position reference model.
module tb_ro_sweep_ctrl;

   localparam int S   = 4;
   localparam int W   = 3;
   localparam int NCH = 2;
`ifdef RO_SWEEP_AUTO_REARM_EN
   localparam bit REARM = 1'b1;
`else
   localparam bit REARM = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic roen = 1'b0;

   logic           counteren, busy, done, aborted;
   logic [NCH-1:0] ro_sel;
   logic [0:0]     ch_idx;
   logic [1:0]     st;

   logic       ce1, busy1, done1, ab1;
   logic [0:0] sel1, ch1;
   logic [1:0] st1;

   always #5 clk = ~clk;

   ro_sweep_ctrl #(.CNT_W(8), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .NUM_CH(NCH)) dut (
      .clk(clk), .rst(rst), .roen(roen), .counteren(counteren), .ro_sel(ro_sel),
      .ch_idx(ch_idx), .counter_ctrl_state(st), .busy(busy), .done(done), .aborted(aborted)
   );

   ro_sweep_ctrl #(.CNT_W(4), .SETTLE_CYCLES(1), .WINDOW_CYCLES(1), .NUM_CH(1)) dut1 (
      .clk(clk), .rst(rst), .roen(roen), .counteren(ce1), .ro_sel(sel1),
      .ch_idx(ch1), .counter_ctrl_state(st1), .busy(busy1), .done(done1), .aborted(ab1)
   );

   int npass = 0;
   int ntot  = 0;
   int cyc   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      else npass++;
   endtask

   // Reference model: mode 0 idle, 1 sweeping (p = cycles into sweep), 2 done.
   int m_mode = 0;
   int m_p    = 0;
   bit m_done = 0;
   bit m_ab   = 0;

   task automatic model_step(input bit r, input bit e);
      m_done = 0;
      m_ab   = 0;
      if (r) m_mode = 0;
      else case (m_mode)
         0: if (e) begin m_mode = 1; m_p = 0; end
         1: if (!e) begin m_mode = 0; m_ab = 1; end
            else begin
               m_p++;
               if (m_p == NCH * (S + W)) begin m_mode = 2; m_done = 1; end
            end
         default: if (!e) m_mode = 0;
                  else if (REARM) begin m_mode = 1; m_p = 0; end
      endcase
   endtask

   task automatic model_check();
      int es, ech;
      logic [NCH-1:0] esel;
      es   = (m_mode == 1) ? (((m_p % (S + W)) < S) ? 1 : 2) : (m_mode == 2 ? 3 : 0);
      ech  = (m_mode == 1) ? (m_p / (S + W)) : (m_mode == 2 ? NCH - 1 : 0);
      esel = (m_mode == 1) ? NCH'(1 << ech) : '0;
      chk("m_state", st, es);
      chk("m_counteren", counteren, (es == 2));
      chk("m_busy", busy, (m_mode == 1));
      chk("m_ro_sel", ro_sel, esel);
      chk("m_ch_idx", ch_idx, ech);
      chk("m_done", done, m_done);
      chk("m_aborted", aborted, m_ab);
   endtask

   // One clock: inputs applied after the falling edge, outputs sampled at the next one.
   task automatic drive(input bit r, input bit e);
      rst  = r;
      roen = e;
      @(posedge clk);
      model_step(r, e);
      cyc++;
      @(negedge clk);
      model_check();
   endtask

   typedef struct packed {
      bit       r;
      bit       e;
      bit [1:0] st;
      bit       ce;
      bit [1:0] sel;
      bit       ch;
      bit       dn;
      bit       ab;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, e, input bit [1:0] s, input bit c, input bit [1:0] sl,
                      input bit h, d, a);
      vec_t v;
      v.r = r; v.e = e; v.st = s; v.ce = c; v.sel = sl; v.ch = h; v.dn = d; v.ab = a;
      tbl.push_back(v);
   endtask

   initial begin
      int last_done;
      int n_done;
      @(negedge clk);

      // Full sweep with roen held, expected outputs after each edge.
      add(1, 0, 2'd0, 0, 2'b00, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 2'd1, 0, 2'b01, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 2'd2, 1, 2'b01, 0, 0, 0);
      for (int i = 0; i < 4; i++) add(0, 1, 2'd1, 0, 2'b10, 1, 0, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 2'd2, 1, 2'b10, 1, 0, 0);
      add(0, 1, 2'd3, 0, 2'b00, 1, 1, 0);
      add(0, 0, 2'd0, 0, 2'b00, 0, 0, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].e);
         chk($sformatf("tbl%0d", i), {st, counteren, ro_sel, ch_idx, done, aborted},
             {tbl[i].st, tbl[i].ce, tbl[i].sel, tbl[i].ch, tbl[i].dn, tbl[i].ab});
      end

      // Abort on the second WINDOW cycle of ch0.
      drive(1, 0);
      for (int i = 0; i < 6; i++) drive(0, 1);
      chk("ab_win_pre", {st, counteren}, {2'd2, 1'b1});
      drive(0, 0);
      chk("ab_win", {st, counteren, aborted, done}, {2'd0, 1'b0, 1'b1, 1'b0});
      drive(0, 0);
      chk("ab_win_pulse", {aborted, done}, 2'b00);

      // Abort during ch1 SETTLE, then restart at ch0.
      drive(1, 0);
      for (int i = 0; i < 9; i++) drive(0, 1);
      chk("ab_set_pre", {st, ch_idx}, {2'd1, 1'b1});
      drive(0, 0);
      chk("ab_set", {aborted, ro_sel, ch_idx}, {1'b1, 2'b00, 1'b0});
      drive(0, 1);
      chk("ab_restart", {st, ro_sel, ch_idx}, {2'd1, 2'b01, 1'b0});

      // Reset mid-WINDOW overrides roen and suppresses aborted.
      drive(1, 0);
      for (int i = 0; i < 6; i++) drive(0, 1);
      drive(1, 1);
      chk("rst_win", {st, counteren, ro_sel, ch_idx, busy, done, aborted}, 9'd0);
      drive(0, 1);
      chk("rst_restart", {st, ro_sel, ch_idx}, {2'd1, 2'b01, 1'b0});

      // Minimal timings instance: counteren at E+1, done at E+2.
      drive(1, 0);
      chk("min_rst", {st1, ce1, sel1, done1, ab1}, 6'd0);
      drive(0, 1);
      chk("min_e0", {st1, ce1, sel1}, {2'd1, 1'b0, 1'b1});
      drive(0, 1);
      chk("min_e1", {st1, ce1, done1}, {2'd2, 1'b1, 1'b0});
      drive(0, 1);
      chk("min_e2", {st1, ce1, done1}, {2'd3, 1'b0, 1'b1});
      drive(0, 0);

`ifdef RO_SWEEP_AUTO_REARM_EN
      // Continuous sweeps: done period is 2*(S+W)+1.
      drive(1, 0);
      last_done = -1;
      n_done = 0;
      for (int i = 0; i < 50; i++) begin
         drive(0, 1);
         if (done) begin
            if (last_done >= 0) chk("rearm_period", cyc - last_done, 2 * (S + W) + 1);
            last_done = cyc;
            n_done++;
         end
      end
      chk("rearm_count", n_done, 3);
`else
      // DONE holds while roen stays high.
      drive(1, 0);
      for (int i = 0; i < 15; i++) drive(0, 1);
      n_done = 0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 1);
         if (done) n_done++;
      end
      chk("done_hold", {st, n_done[3:0]}, {2'd3, 4'd0});
      last_done = 0;
`endif

      // Random roen/rst against the model.
      drive(1, 0);
      for (int i = 0; i < 3000; i++) begin
         bit r, e;
         r = ($urandom_range(0, 199) == 0);
         e = ($urandom_range(0, 19) == 0) ? ~roen : roen;
         drive(r, e);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
